multiword_add_seq: RTL

MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

---
 rtl/multiword_add_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/multiword_add_seq.sv
// Multi-word adder that time-multiplexes one N-bit adder over WORDS operand words.
// An accepted start latches the operands and adds one word per cycle, LSW first.

module nBitAdder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum_c,
  output logic         cout_c
);

  assign {cout_c, sum_c} = (N+1)'(a) + (N+1)'(b) + (N+1)'(cin);

endmodule

module multiword_add_seq #(
  parameter int unsigned N     = 8,
  parameter int unsigned WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N*WORDS-1:0]   a_in,
  input  logic [N*WORDS-1:0]   b_in,
  input  logic                 cin,
  output logic [N*WORDS-1:0]   sum_out,
  output logic                 cout,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned W  = N * WORDS;
  localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic           carry;
  logic [IW-1:0]  idx;

  logic [N-1:0]   a_word;
  logic [N-1:0]   b_word;
  logic [N-1:0]   add_sum;
  logic           add_cout;

  // Select the operand words addressed by idx
  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int i = 0; i < int'(WORDS); i++) begin
      if (idx == IW'(i)) begin
        a_word = a_reg[i*N +: N];
        b_word = b_reg[i*N +: N];
      end
    end
  end

  nBitAdder #(
    .N (N)
  ) u_adder (
    .a      (a_word),
    .b      (b_word),
    .cin    (carry),
    .sum_c  (add_sum),
    .cout_c (add_cout)
  );

  // Control FSM with datapath registers; busy/done are registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      sum_out <= '0;
      cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= a_in;
            b_reg <= b_in;
            carry <= cin;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          for (int i = 0; i < int'(WORDS); i++) begin
            if (idx == IW'(i)) begin
              sum_out[i*N +: N] <= add_sum;
            end
          end
          carry <= add_cout;
          if (idx == IW'(WORDS - 1)) begin
            idx   <= '0;
            cout  <= add_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
